// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command front-end for the arithmetic_unit ALU. Commands are queued in a
//   DEPTH-entry FIFO. They are issued one at a time to the combinational ALU,
//   and each registered result is returned on a response port.
//
//   Build option: define ALU_SEQ_DIVZERO_EN to flag divide-by-zero.
//   With it, opcode 0011 and alu_b == 0 return 16'hFFFF with rsp_err = 1.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_ready = FIFO not full
//   cmd_opcode, cmd_a, cmd_b  command payload (opcode 4b, operands 8b)
//   alu_opcode, alu_a, alu_b  registered operands driven into the ALU
//   alu_result                combinational ALU result (16b)
//   rsp_valid/rsp_ready       response handshake
//   rsp_result, rsp_opcode,
//   rsp_err                   response payload
//   fifo_count                occupied FIFO entries
//   dbg_state                 current FSM state (IDLE=0, EXEC=1, RESP=2)
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Once a producer raises valid, it holds valid and the payload stable until
// that transfer. ready may toggle freely. Here rsp_* stay stable while
// rsp_valid is high.

module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_opcode,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  output logic [3:0]               alu_opcode,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  input  logic [15:0]              alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_result,
  output logic [3:0]               rsp_opcode,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // FIFO storage: {opcode, a, b}
  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [19:0]   head;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (fifo_count == '0);
  assign cmd_ready  = (fifo_count != FULL_COUNT);
  assign push       = cmd_valid && cmd_ready;
  // pop depends only on the registered count, so an entry pushed this
  // cycle into an empty FIFO cannot be popped in the same cycle.
  assign pop        = !fifo_empty &&
                      ((state == IDLE) || (state == RESP && rsp_ready));
  assign dbg_state  = state;

  // Pointers are AW bits wide and DEPTH is a power of two,
  // so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Response value captured at the end of EXEC
  logic [15:0] cap_result;
  logic        cap_err;

  always_comb begin
    cap_result = alu_result;
    cap_err    = 1'b0;
    if (alu_opcode > 4'd9) begin
      // Illegal opcode: the ALU output is meaningless, so it is discarded.
      cap_result = 16'h0000;
      cap_err    = 1'b1;
    end
`ifdef ALU_SEQ_DIVZERO_EN
    else if (alu_opcode == 4'd3 && alu_b == 8'd0) begin
      cap_result = 16'hFFFF;
      cap_err    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_opcode <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {alu_opcode, alu_a, alu_b} <= head;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= cap_result;
          rsp_err    <= cap_err;
          rsp_opcode <= alu_opcode;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            // Chaining straight into EXEC gives one response per 2 cycles.
            if (pop) begin
              {alu_opcode, alu_a, alu_b} <= head;
              state <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer.
// A stand-in ALU model drives alu_result from the DUT's alu_* outputs.
// The expected response per command comes from the opcode rules.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.

module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_opcode;
  logic        rsp_err;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [1:0]  dbg_state;

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_opcode (rsp_opcode),
    .rsp_err    (rsp_err),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stand-in ALU and reference model ----------------
  // Opcode map: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR,
  // 8 NAND, 9 XNOR. Division by zero returns 16'hBEEF so the result is
  // easy to recognise. Illegal opcodes return garbage that must be dropped.
  function automatic logic [15:0] alu_fn(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (op)
      4'd0: return wa + wb;
      4'd1: return wa - wb;
      4'd2: return wa * wb;
      4'd3: return (b == 8'd0) ? 16'hBEEF : wa / wb;
      4'd4: return (b == 8'd0) ? 16'hBEEF : wa % wb;
      4'd5: return wa & wb;
      4'd6: return wa | wb;
      4'd7: return wa ^ wb;
      4'd8: return {8'h00, ~(a & b)};
      4'd9: return {8'h00, ~(a ^ b)};
      default: return 16'hA5A5;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);

  // Expected response {opcode, result, err} for one command
  function automatic logic [20:0] model(input logic [3:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    if (op >= 4'd10) return {op, 16'h0000, 1'b1};
`ifdef ALU_SEQ_DIVZERO_EN
    if (op == 4'd3 && b == 8'd0) return {op, 16'hFFFF, 1'b1};
`endif
    return {op, alu_fn(op, a, b), 1'b0};
  endfunction

  // ---------------- scoreboard ----------------
  logic [20:0] exp_q[$];
  logic [20:0] obs_q[$];
  int unsigned obs_t[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  // Record every response that will transfer on the coming edge.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      obs_q.push_back({rsp_opcode, rsp_result, rsp_err});
      obs_t.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    obs_t.delete();
  endtask

  // Offer one command until accepted or budget runs out. Returns 1 time
  // unit after the acceptance edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input int budget, output bit ok);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (ok) exp_q.push_back(model(op, a, b));
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = 8'd1; cmd_b = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); else pass_cnt++;
    total_cnt++;
    if (rsp_result !== 16'h0) $display("FAIL reset_rsp_result got %h want 0000", rsp_result); else pass_cnt++;
    total_cnt++;
    if ({rsp_opcode, rsp_err} !== 5'h0) $display("FAIL reset_rsp_op_err got %h/%0b want 0/0", rsp_opcode, rsp_err); else pass_cnt++;
    total_cnt++;
    if ({alu_opcode, alu_a, alu_b} !== 20'h0) $display("FAIL reset_alu got %h %h %h want 0 0 0", alu_opcode, alu_a, alu_b); else pass_cnt++;
    total_cnt++;
    if (fifo_count !== '0) $display("FAIL reset_fifo_count got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    bit ok;
    logic [20:0] r;
    do_reset();
    rsp_ready = 1'b0;
    send(4'd0, 8'd15, 8'd3, 10, ok);       // accepted at edge N
    @(negedge clk);                        // between N and N+1
    total_cnt++;
    if (!ok || rsp_valid !== 1'b0) $display("FAIL add_early_valid accepted=%0b rsp_valid=%0b want 1/0", ok, rsp_valid); else pass_cnt++;
    @(negedge clk);                        // after N+1: popped into alu_*
    total_cnt++;
    if ({alu_opcode, alu_a, alu_b, rsp_valid} !== {4'd0, 8'd15, 8'd3, 1'b0})
      $display("FAIL add_pop alu=%h,%0d,%0d valid=%0b want 0,15,3 valid=0", alu_opcode, alu_a, alu_b, rsp_valid);
    else pass_cnt++;
    @(negedge clk);                        // after N+2
    r = {rsp_opcode, rsp_result, rsp_err};
    total_cnt++;
    if (rsp_valid !== 1'b1 || r !== {4'd0, 16'd18, 1'b0})
      $display("FAIL add_result valid=%0b result=%0d err=%0b want valid=1 result=18 err=0", rsp_valid, rsp_result, rsp_err);
    else pass_cnt++;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain(10, ok);
    total_cnt++;
    if (!ok || obs_q.size() != 1) $display("FAIL add_drain got %0d responses want 1", obs_q.size()); else pass_cnt++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    rsp_ready = 1'b1;
    send(4'd2, 8'd15, 8'd3, 10, ok);
    send(4'd3, 8'd15, 8'd3, 10, ok);
    send(4'd7, 8'd15, 8'd3, 10, ok);
    wait_drain(40, ok);
    total_cnt++;
    if (!ok || obs_q.size() != 3) $display("FAIL b2b_count got %0d want 3", obs_q.size());
    else pass_cnt++;
    if (obs_q.size() == 3) begin
      total_cnt++;
      if (obs_q[0][16:1] !== 16'd45 || obs_q[1][16:1] !== 16'd5 || obs_q[2][16:1] !== 16'd12)
        $display("FAIL b2b_values got %0d,%0d,%0d want 45,5,12", obs_q[0][16:1], obs_q[1][16:1], obs_q[2][16:1]);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_rsp%0d got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
      end
      total_cnt++;
      if (obs_t[1] - obs_t[0] != 2 || obs_t[2] - obs_t[1] != 2)
        $display("FAIL b2b_spacing got %0d,%0d want 2,2", obs_t[1] - obs_t[0], obs_t[2] - obs_t[1]);
      else pass_cnt++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int accepted;
    bit stable;
    logic [20:0] held;
    do_reset();
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom_range(0, 255)), 1, ok);
      if (ok) accepted++;
    end
    @(negedge clk);
    total_cnt++;
    if (accepted != 5) $display("FAIL bp_accepted got %0d want 5", accepted); else pass_cnt++;
    total_cnt++;
    if (cmd_ready !== 1'b0 || fifo_count !== 3'd4)
      $display("FAIL bp_full cmd_ready=%0b fifo_count=%0d want 0/4", cmd_ready, fifo_count);
    else pass_cnt++;
    held = {rsp_opcode, rsp_result, rsp_err};
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || {rsp_opcode, rsp_result, rsp_err} !== held) stable = 1'b0;
    end
    total_cnt++;
    if (!stable || held !== exp_q[0]) $display("FAIL bp_stall_hold stable=%0b held=%h want 1/%h", stable, held, exp_q[0]); else pass_cnt++;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain(60, ok);
    total_cnt++;
    if (!ok || obs_q.size() != 5) $display("FAIL bp_drain got %0d want 5", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL bp_rsp%0d got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_illegal_and_divzero();
    bit ok;
    do_reset();
    rsp_ready = 1'b1;
    send(4'd12, 8'd7, 8'd9, 10, ok);
    send(4'd3, 8'd15, 8'd0, 10, ok);
    wait_drain(40, ok);
    total_cnt++;
    if (!ok || obs_q.size() != 2) $display("FAIL special_count got %0d want 2", obs_q.size()); else pass_cnt++;
    if (obs_q.size() == 2) begin
      total_cnt++;
      if (obs_q[0] !== {4'd12, 16'h0000, 1'b1}) $display("FAIL illegal_rsp got %h want %h", obs_q[0], {4'd12, 16'h0000, 1'b1}); else pass_cnt++;
`ifdef ALU_SEQ_DIVZERO_EN
      total_cnt++;
      if (obs_q[1] !== {4'd3, 16'hFFFF, 1'b1}) $display("FAIL divzero_rsp got %h want %h", obs_q[1], {4'd3, 16'hFFFF, 1'b1}); else pass_cnt++;
`else
      total_cnt++;
      if (obs_q[1] !== {4'd3, 16'hBEEF, 1'b0}) $display("FAIL divzero_rsp got %h want %h", obs_q[1], {4'd3, 16'hBEEF, 1'b0}); else pass_cnt++;
`endif
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    bit sent_all;
    int n_ok;
    do_reset();
    sent_all = 1'b0;
    n_ok = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send(4'($urandom_range(0, 15)), 8'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom), 60, ok);
          if (ok) n_ok++;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        sent_all = 1'b1;
      end
      begin
        for (int i = 0; i < 3000; i++) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
          if (sent_all && obs_q.size() >= exp_q.size()) break;
        end
        rsp_ready = 1'b1;
      end
    join
    wait_drain(20, ok);
    total_cnt++;
    if (!ok || n_ok != 24 || obs_q.size() != 24) $display("FAIL rand_count accepted=%0d got %0d want 24/24", n_ok, obs_q.size()); else pass_cnt++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rand_rsp%0d got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit stale;
    do_reset();
    rsp_ready = 1'b0;
    // c0 accepted at N..c3 at N+3; c0 waits in RESP with c1..c3 buffered
    for (int i = 0; i < 4; i++) send(4'd0, 8'(i + 1), 8'd1, 4, ok);
    rsp_ready = 1'b1;
    @(posedge clk); #1;                    // c1 popped: EXEC, 2 buffered
    total_cnt++;
    if (fifo_count !== 3'd2) $display("FAIL mid_setup fifo_count got %0d want 2", fifo_count); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    obs_t.delete();
    @(negedge clk);
    total_cnt++;
    if ({rsp_valid, rsp_result, rsp_opcode, rsp_err, alu_opcode, alu_a, alu_b} !== 46'h0 ||
        fifo_count !== '0 || cmd_ready !== 1'b1)
      $display("FAIL mid_reset_outputs valid=%0b res=%h op=%h err=%0b alu=%h,%h,%h cnt=%0d rdy=%0b want all 0, rdy=1",
               rsp_valid, rsp_result, rsp_opcode, rsp_err, alu_opcode, alu_a, alu_b, fifo_count, cmd_ready);
    else pass_cnt++;
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || fifo_count !== '0) stale = 1'b1;
    end
    total_cnt++;
    if (stale || obs_q.size() != 0) $display("FAIL mid_no_stale stale=%0b responses=%0d want 0/0", stale, obs_q.size()); else pass_cnt++;
    rsp_ready = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_opcode = '0;
    cmd_a = '0;
    cmd_b = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_illegal_and_divzero();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end for the `arithmetic_unit` ALU. It accepts opcode/operand commands through a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time to the combinational ALU, registers each result and returns it through a valid/ready response port. It is upstream of the ALU (it drives its inputs) and also consumes its output. Illegal opcodes are flagged, and optionally divide-by-zero as well.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, 2..16.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals not-full.
- `cmd_opcode`  in  4  ALU opcode (0000 ADD .. 1001 XNOR).
- `cmd_a`, `cmd_b`  in  8  operands.
- `alu_opcode`  out  4  registered opcode to ALU.
- `alu_a`, `alu_b`  out  8  registered operands to ALU.
- `alu_result`  in  16  combinational ALU result.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  16  captured result.
- `rsp_opcode`  out  4  opcode of the response.
- `rsp_err`  out  1  error flag for the response.
- `fifo_count`  out  clog2(DEPTH)+1  occupied FIFO entries.

## Operation
- FIFO write occurs on `cmd_valid && cmd_ready`.
- `cmd_ready` is low when the FIFO holds `DEPTH` entries. It does not depend on a same-cycle pop.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head into the `alu_*` registers and go to EXEC.
  - EXEC: capture the response into `rsp_*`, set `rsp_valid`, go to RESP.
  - RESP: hold `rsp_*` stable. On `rsp_ready`, clear `rsp_valid`. If the FIFO is non-empty at that edge, pop the head straight into the `alu_*` registers and go to EXEC; otherwise go to IDLE.
- Legal opcodes are 0000–1001: `rsp_result = alu_result`, `rsp_err = 0`.
- Illegal opcodes are 1010–1111: `rsp_result = 16'h0000`, `rsp_err = 1`, and `alu_result` is ignored. The command still produces exactly one response.
- Responses are produced in command order, one per accepted command, with no drops.
- A simultaneous push and pop in one cycle is legal. `fifo_count` is unchanged, and a push into an empty FIFO is never popped in the same cycle.
- FIFO pointers wrap modulo `DEPTH`.

## Timing
- Command accepted at edge N into an empty FIFO, FSM in IDLE:
  - pop at edge N+1;
  - `rsp_valid` is high after edge N+2, a 2-cycle latency.
- Back-to-back throughput is one response per 2 cycles when `rsp_ready` is held high.
- `alu_*` outputs stay stable from the pop through the EXEC capture edge.
- Reset (any state, including mid-command):
  - FIFO emptied, `fifo_count = 0`;
  - state set to IDLE;
  - `rsp_valid = 0`, `rsp_result = 0`, `rsp_opcode = 0`, `rsp_err = 0`;
  - `alu_opcode = 0`, `alu_a = 0`, `alu_b = 0`;
  - `cmd_ready = 1` in the first cycle after reset.
- `cmd_valid` asserted during reset is not accepted.
- In-flight and buffered commands are discarded on reset and produce no response.

## Configuration
- Macro `ALU_SEQ_DIVZERO_EN`.
- Defined: opcode 0011 with `alu_b == 0` gives `rsp_result = 16'hFFFF`, `rsp_err = 1`.
- Undefined: that case passes `alu_result` unmodified with `rsp_err = 0`. Only illegal opcodes set `rsp_err`.

## Test plan
- ADD: opcode 0000, a=15, b=3 → `rsp_result = 18`, `rsp_err = 0`, `rsp_valid` high 2 cycles after acceptance.
- Sequence with `rsp_ready = 1`: MUL 15×3, DIV 15/3, XOR 15^3 → responses 45, 5, 12 in order, spaced 2 cycles apart.
- Backpressure, DEPTH=4, `rsp_ready = 0`:
  - push 6 commands → 5 accepted (1 in flight, 4 buffered), `cmd_ready` drops, `fifo_count = 4`;
  - release `rsp_ready` → all 5 responses arrive in order, stable while stalled.
- Illegal opcode 1100, a=7, b=9 → `rsp_result = 0`, `rsp_err = 1`, `rsp_opcode = 1100`.
- DIV, a=15, b=0:
  - with `ALU_SEQ_DIVZERO_EN` → `rsp_result = 16'hFFFF`, `rsp_err = 1`;
  - without it → `rsp_result` equals the ALU output, `rsp_err = 0`.
- Reset mid-operation: assert `rst` in EXEC with 2 entries buffered → next cycle all outputs are 0 except `cmd_ready = 1`, and no stale response ever appears.
